rule_match_classifier: RTL and testbench

RULE_MATCH_CLASSIFIER -- requirements
Module: rule_match_classifier

---
 rtl/rule_match_pkg.sv | 27 ++
 rtl/rule_match_prio_enc.sv | 46 ++++
 rtl/rule_match_classifier.sv | 215 +++++++++++++++++++++
 tb/tb_rule_match_classifier.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/rule_match_pkg.sv
// -----------------------------------------------------------------------------
// rule_match_pkg
//   Shared types for the rule match classifier.
//   - state_t : controller states (IDLE, READ, WRITE, ERROR)
//   - rule_t  : one rule-table slot {en, value, mask}; mask bit 1 = don't-care
//   Rule value/mask fields are sized to RULE_W_MAX. Narrower data words are
//   zero-extended, so the unused upper bits always compare equal. DATA_W of
//   any user must not exceed RULE_W_MAX.
// -----------------------------------------------------------------------------
package rule_match_pkg;

    localparam int unsigned RULE_W_MAX = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        ERROR = 2'd3
    } state_t;

    typedef struct packed {
        logic                  en;
        logic [RULE_W_MAX-1:0] value;
        logic [RULE_W_MAX-1:0] mask;
    } rule_t;

endpackage

// File: rtl/rule_match_prio_enc.sv
// -----------------------------------------------------------------------------
// rule_match_prio_enc
//   Purely combinational rule matcher and priority encoder.
//   Ports:
//     i_rules  : rule table, one rule_t per slot
//     i_data   : zero-extended word to classify
//     o_match  : per-rule match vector (enabled and all cared bits equal)
//     o_idx    : lowest matching index, 0 when nothing matches
//     o_multi  : more than one rule matches
// -----------------------------------------------------------------------------
module rule_match_prio_enc
    import rule_match_pkg::*;
#(
    parameter int unsigned NUM_RULES = 4
) (
    input  rule_t [NUM_RULES-1:0]         i_rules,
    input  logic  [RULE_W_MAX-1:0]        i_data,
    output logic  [NUM_RULES-1:0]         o_match,
    output logic  [$clog2(NUM_RULES)-1:0] o_idx,
    output logic                          o_multi
);

    localparam int unsigned IDX_W = $clog2(NUM_RULES);

    always_comb begin
        o_match = '0;
        for (int unsigned i = 0; i < NUM_RULES; i++) begin
            o_match[i] = i_rules[i].en &&
                         (((i_data ^ i_rules[i].value) & ~i_rules[i].mask) == '0);
        end
    end

    // Scan from the top down so the lowest matching index is written last.
    always_comb begin
        o_idx = '0;
        for (int unsigned i = NUM_RULES; i > 0; i--) begin
            if (o_match[i-1]) begin
                o_idx = IDX_W'(i - 1);
            end
        end
    end

    // Clearing the lowest set bit leaves something only if two or more are set.
    assign o_multi = |(o_match & (o_match - NUM_RULES'(1)));

endmodule

// File: rtl/rule_match_classifier.sv
// -----------------------------------------------------------------------------
// rule_match_classifier
//   Classifies one DATA_W word at a time against a programmable table of
//   NUM_RULES value/mask rules. Lowest matching enabled rule wins. One item in
//   flight: accept (IDLE) -> compare (READ) -> hold result (WRITE/ERROR) until
//   downstream takes it. Delivered hits are counted in a saturating counter.
//
//   Ports:
//     in_clk, in_rst       : clock, synchronous active-high reset
//     in_valid, in_data    : word to classify, accepted when out_ready=1
//     in_ready_dn          : downstream accepts the held result
//     in_cfg_we/idx/value/mask/en : rule-table write port (any state)
//     out_ready            : block is idle and can accept in_data
//     out_valid            : result held on out_hit/out_category/out_error
//     out_hit_cnt          : saturating count of delivered hits
//
//   Optional build macro RULE_UNIQUE_CHECK_EN: a multi-rule match goes to the
//   ERROR state and is delivered with out_error=1 (still a hit, lowest index).
//   Without it, ERROR is unreachable and out_error is constant 0.
// -----------------------------------------------------------------------------
module rule_match_classifier
    import rule_match_pkg::*;
#(
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned NUM_RULES = 4,
    parameter int unsigned CNT_W     = 16
) (
    input  logic                         in_clk,
    input  logic                         in_rst,
    input  logic                         in_valid,
    input  logic                         in_ready_dn,
    input  logic [DATA_W-1:0]            in_data,
    input  logic                         in_cfg_we,
    input  logic [$clog2(NUM_RULES)-1:0] in_cfg_idx,
    input  logic [DATA_W-1:0]            in_cfg_value,
    input  logic [DATA_W-1:0]            in_cfg_mask,
    input  logic                         in_cfg_en,
    output logic                         out_ready,
    output logic                         out_valid,
    output logic                         out_hit,
    output logic [$clog2(NUM_RULES)-1:0] out_category,
    output logic                         out_error,
    output logic [CNT_W-1:0]             out_hit_cnt
);

    localparam int unsigned IDX_W = $clog2(NUM_RULES);

`ifdef RULE_UNIQUE_CHECK_EN
    localparam bit UNIQUE_EN = 1'b1;
`else
    localparam bit UNIQUE_EN = 1'b0;
`endif

    state_t                        r_state;
    state_t                        w_next;
    rule_t [NUM_RULES-1:0]         r_rules;
    logic  [DATA_W-1:0]            r_data;
    logic                          r_hit;
    logic  [IDX_W-1:0]             r_cat;
    logic  [CNT_W-1:0]             r_hit_cnt;

    logic  [RULE_W_MAX-1:0]        w_data_ext;
    logic  [NUM_RULES-1:0]         w_match;
    logic  [IDX_W-1:0]             w_idx;
    logic                          w_multi;
    logic                          w_any;
    logic                          w_accept;
    logic                          w_deliver;
    logic                          w_cfg_ok;

    // ------------------------------------------------------------------
    // Match / priority resolution on the latched word and current table
    // ------------------------------------------------------------------
    assign w_data_ext = RULE_W_MAX'(r_data);

    rule_match_prio_enc #(
        .NUM_RULES (NUM_RULES)
    ) u_prio_enc (
        .i_rules (r_rules),
        .i_data  (w_data_ext),
        .o_match (w_match),
        .o_idx   (w_idx),
        .o_multi (w_multi)
    );

    assign w_any = |w_match;

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge in_clk) begin
        if (in_rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE: begin
                if (in_valid) begin
                    w_next = READ;
                end
            end
            READ: begin
                w_next = (UNIQUE_EN && w_multi) ? ERROR : WRITE;
            end
            WRITE, ERROR: begin
                if (in_ready_dn) begin
                    w_next = IDLE;
                end
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs decoded from the state register
    // ------------------------------------------------------------------
    always_comb begin
        out_ready = 1'b0;
        out_valid = 1'b0;
        unique case (r_state)
            IDLE:         out_ready = 1'b1;
            WRITE, ERROR: out_valid = 1'b1;
            default: begin
                out_ready = 1'b0;
                out_valid = 1'b0;
            end
        endcase
    end

    assign w_accept  = (r_state == IDLE) && in_valid;
    assign w_deliver = out_valid && in_ready_dn;

    // ------------------------------------------------------------------
    // Input word latch
    // ------------------------------------------------------------------
    always_ff @(posedge in_clk) begin
        if (in_rst) begin
            r_data <= '0;
        end else if (w_accept) begin
            r_data <= in_data;
        end
    end

    // ------------------------------------------------------------------
    // Result registers: loaded only in READ, held otherwise
    // ------------------------------------------------------------------
    always_ff @(posedge in_clk) begin
        if (in_rst) begin
            r_hit <= 1'b0;
            r_cat <= '0;
        end else if (r_state == READ) begin
            r_hit <= w_any;
            r_cat <= w_idx;
        end
    end

`ifdef RULE_UNIQUE_CHECK_EN
    logic r_error;

    always_ff @(posedge in_clk) begin
        if (in_rst) begin
            r_error <= 1'b0;
        end else if (r_state == READ) begin
            r_error <= w_multi;
        end
    end

    assign out_error = r_error;
`else
    assign out_error = 1'b0;
`endif

    assign out_hit      = r_hit;
    assign out_category = r_cat;

    // ------------------------------------------------------------------
    // Saturating hit counter, advanced when a hit result is taken
    // ------------------------------------------------------------------
    always_ff @(posedge in_clk) begin
        if (in_rst) begin
            r_hit_cnt <= '0;
        end else if (w_deliver && r_hit && (r_hit_cnt != '1)) begin
            r_hit_cnt <= r_hit_cnt + CNT_W'(1);
        end
    end

    assign out_hit_cnt = r_hit_cnt;

    // ------------------------------------------------------------------
    // Rule table. The comparison in READ sees the table before this edge,
    // so a write landing in the READ cycle only affects later words.
    // ------------------------------------------------------------------
    assign w_cfg_ok = in_cfg_we && (32'(in_cfg_idx) < NUM_RULES);

    always_ff @(posedge in_clk) begin
        if (in_rst) begin
            r_rules <= '0;
        end else if (w_cfg_ok) begin
            r_rules[in_cfg_idx] <= '{en:    in_cfg_en,
                                     value: RULE_W_MAX'(in_cfg_value),
                                     mask:  RULE_W_MAX'(in_cfg_mask)};
        end
    end

endmodule

// File: tb/tb_rule_match_classifier.sv
// -----------------------------------------------------------------------------
// tb_rule_match_classifier
//   Two instances share all inputs: one with a 16-bit hit counter, one with a
//   2-bit counter so saturation is exercised alongside normal counting. Uses
//   NUM_RULES=5 so out-of-range config indices exist on the 3-bit index port.
// -----------------------------------------------------------------------------
module tb_rule_match_classifier;

    localparam int unsigned NR = 5;
    localparam int unsigned IW = $clog2(NR);

    logic          in_clk = 1'b0;
    logic          in_rst;
    logic          in_valid;
    logic          in_ready_dn;
    logic [7:0]    in_data;
    logic          in_cfg_we;
    logic [IW-1:0] in_cfg_idx;
    logic [7:0]    in_cfg_value;
    logic [7:0]    in_cfg_mask;
    logic          in_cfg_en;

    logic          a_ready, a_valid, a_hit, a_err;
    logic [IW-1:0] a_cat;
    logic [15:0]   a_cnt;
    logic          b_ready, b_valid, b_hit, b_err;
    logic [IW-1:0] b_cat;
    logic [1:0]    b_cnt;

    always #5 in_clk = ~in_clk;

    rule_match_classifier #(.DATA_W(8), .NUM_RULES(NR), .CNT_W(16)) u_dut_a (
        .in_clk (in_clk), .in_rst (in_rst), .in_valid (in_valid),
        .in_ready_dn (in_ready_dn), .in_data (in_data),
        .in_cfg_we (in_cfg_we), .in_cfg_idx (in_cfg_idx),
        .in_cfg_value (in_cfg_value), .in_cfg_mask (in_cfg_mask),
        .in_cfg_en (in_cfg_en),
        .out_ready (a_ready), .out_valid (a_valid), .out_hit (a_hit),
        .out_category (a_cat), .out_error (a_err), .out_hit_cnt (a_cnt)
    );

    rule_match_classifier #(.DATA_W(8), .NUM_RULES(NR), .CNT_W(2)) u_dut_b (
        .in_clk (in_clk), .in_rst (in_rst), .in_valid (in_valid),
        .in_ready_dn (in_ready_dn), .in_data (in_data),
        .in_cfg_we (in_cfg_we), .in_cfg_idx (in_cfg_idx),
        .in_cfg_value (in_cfg_value), .in_cfg_mask (in_cfg_mask),
        .in_cfg_en (in_cfg_en),
        .out_ready (b_ready), .out_valid (b_valid), .out_hit (b_hit),
        .out_category (b_cat), .out_error (b_err), .out_hit_cnt (b_cnt)
    );

    // Reference model
    logic       m_en   [NR];
    logic [7:0] m_val  [NR];
    logic [7:0] m_mask [NR];
    int         m_cnt;
    logic       m_hit;
    logic [2:0] m_cat;
    logic       m_err;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic v, input logic r);
        check({tag, "/a_valid"}, 32'(a_valid), 32'(v));
        check({tag, "/a_ready"}, 32'(a_ready), 32'(r));
        check({tag, "/a_hit"},   32'(a_hit),   32'(m_hit));
        check({tag, "/a_cat"},   32'(a_cat),   32'(m_cat));
        check({tag, "/a_err"},   32'(a_err),   32'(m_err));
        check({tag, "/a_cnt"},   32'(a_cnt),   32'(m_cnt & 'hFFFF));
        check({tag, "/b_valid"}, 32'(b_valid), 32'(v));
        check({tag, "/b_ready"}, 32'(b_ready), 32'(r));
        check({tag, "/b_hit"},   32'(b_hit),   32'(m_hit));
        check({tag, "/b_cat"},   32'(b_cat),   32'(m_cat));
        check({tag, "/b_err"},   32'(b_err),   32'(m_err));
        check({tag, "/b_cnt"},   32'(b_cnt),   (m_cnt > 3) ? 32'd3 : 32'(m_cnt));
    endtask

    task automatic tick();
        @(posedge in_clk);
        #1;
    endtask

    function automatic void classify(input logic [7:0] d, output logic h,
                                     output logic [2:0] c, output int n);
        h = 1'b0;
        c = 3'd0;
        n = 0;
        for (int i = 0; i < int'(NR); i++) begin
            if (m_en[i] && (((d ^ m_val[i]) & ~m_mask[i]) == 8'h00)) begin
                if (!h) c = 3'(i);
                h = 1'b1;
                n++;
            end
        end
    endfunction

    function automatic logic err_of(input int n);
`ifdef RULE_UNIQUE_CHECK_EN
        return n > 1;
`else
        return (n < 0);
`endif
    endfunction

    task automatic model_reset();
        for (int i = 0; i < int'(NR); i++) begin
            m_en[i] = 1'b0; m_val[i] = 8'h00; m_mask[i] = 8'h00;
        end
        m_cnt = 0; m_hit = 1'b0; m_cat = 3'd0; m_err = 1'b0;
    endtask

    task automatic model_write(input int idx, input logic [7:0] v, input logic [7:0] m, input logic e);
        if (idx < int'(NR)) begin
            m_en[idx] = e; m_val[idx] = v; m_mask[idx] = m;
        end
    endtask

    task automatic drive_cfg(input int idx, input logic [7:0] v, input logic [7:0] m, input logic e);
        in_cfg_we = 1'b1; in_cfg_idx = IW'(idx);
        in_cfg_value = v; in_cfg_mask = m; in_cfg_en = e;
    endtask

    task automatic cfg_write(input int idx, input logic [7:0] v, input logic [7:0] m, input logic e);
        drive_cfg(idx, v, m, e);
        tick();
        in_cfg_we = 1'b0;
        model_write(idx, v, m, e);
    endtask

    task automatic do_reset();
        in_rst = 1'b1;
        tick();
        in_rst = 1'b0;
        model_reset();
    endtask

    // One full transaction; optional config write during the READ cycle.
    task automatic run_item(input logic [7:0] d, input int stall, input bit wr,
                            input int widx, input logic [7:0] wv, input logic [7:0] wm, input logic we);
        logic       eh;
        logic [2:0] ec;
        int         en;
        check_all("idle", 1'b0, 1'b1);
        in_valid = 1'b1; in_data = d;
        tick();
        in_valid = 1'b0; in_data = 8'($urandom);
        classify(d, eh, ec, en);
        check_all("read", 1'b0, 1'b0);
        if (wr) drive_cfg(widx, wv, wm, we);
        tick();
        in_cfg_we = 1'b0;
        if (wr) model_write(widx, wv, wm, we);
        m_hit = eh; m_cat = ec; m_err = err_of(en);
        check_all("result", 1'b1, 1'b0);
        for (int k = 0; k < stall; k++) begin
            in_valid = 1'b1;
            tick();
            in_valid = 1'b0;
            check_all("stall", 1'b1, 1'b0);
        end
        in_ready_dn = 1'b1;
        tick();
        in_ready_dn = 1'b0;
        if (m_hit) m_cnt++;
        check_all("done", 1'b0, 1'b1);
    endtask

    initial begin
        logic       eh;
        logic [2:0] ec;
        int         en;
        logic [7:0] d;
        int         r;

        in_rst = 1'b1; in_valid = 1'b0; in_ready_dn = 1'b0; in_data = 8'h00;
        in_cfg_we = 1'b0; in_cfg_idx = '0; in_cfg_value = 8'h00;
        in_cfg_mask = 8'h00; in_cfg_en = 1'b0;
        tick();
        do_reset();
        check_all("reset", 1'b0, 1'b1);

        // Empty table: no hit, category 0, count unchanged
        run_item(8'h33, 0, 1'b0, 0, 8'h00, 8'h00, 1'b0);

        // Overlapping rules 0 and 1 both match A5; lowest index wins
        cfg_write(0, 8'hA0, 8'h0F, 1'b1);
        cfg_write(1, 8'hA5, 8'h00, 1'b1);
        run_item(8'hA5, 0, 1'b0, 0, 8'h00, 8'h00, 1'b0);

        // Downstream stalls 5 cycles; a second request is offered meanwhile
        run_item(8'hA5, 5, 1'b0, 0, 8'h00, 8'h00, 1'b0);

        // Enable rule 2 during READ: that word sees the old table
        cfg_write(0, 8'hA0, 8'h0F, 1'b0);
        cfg_write(1, 8'hA5, 8'h00, 1'b0);
        cfg_write(2, 8'h5A, 8'h00, 1'b0);
        run_item(8'h5A, 0, 1'b1, 2, 8'h5A, 8'h00, 1'b1);
        run_item(8'h5A, 1, 1'b0, 0, 8'h00, 8'h00, 1'b0);

        // Out-of-range indices are ignored
        cfg_write(5, 8'h33, 8'hFF, 1'b1);
        cfg_write(7, 8'h33, 8'hFF, 1'b1);
        run_item(8'h33, 0, 1'b0, 0, 8'h00, 8'h00, 1'b0);

        // All-ones mask matches everything; rule 2 still has priority on 5A
        cfg_write(4, 8'h00, 8'hFF, 1'b1);
        run_item(8'hC3, 0, 1'b0, 0, 8'h00, 8'h00, 1'b0);
        run_item(8'h5A, 0, 1'b0, 0, 8'h00, 8'h00, 1'b0);
        run_item(8'h00, 2, 1'b0, 0, 8'h00, 8'h00, 1'b0);

        // Randomized rule tables and words
        for (int round = 0; round < 8; round++) begin
            for (int i = 0; i < int'(NR); i++) begin
                cfg_write(i, 8'($urandom),
                          ($urandom_range(0, 7) == 0) ? 8'hFF : 8'($urandom & $urandom & $urandom),
                          $urandom_range(0, 3) != 0);
            end
            for (int j = 0; j < 6; j++) begin
                if ($urandom_range(0, 1) == 1) begin
                    r = int'($urandom_range(0, NR - 1));
                    d = m_val[r] ^ (8'($urandom) & m_mask[r]);
                end else begin
                    d = 8'($urandom);
                end
                run_item(d, int'($urandom_range(0, 2)), $urandom_range(0, 3) == 0,
                         int'($urandom_range(0, 7)), 8'($urandom), 8'($urandom & $urandom),
                         $urandom_range(0, 1) == 1);
            end
        end

        // Reset while a result is waiting: discarded, nothing counted
        cfg_write(0, 8'hA5, 8'h00, 1'b1);
        check_all("pre_rst", 1'b0, 1'b1);
        in_valid = 1'b1; in_data = 8'hA5;
        tick();
        in_valid = 1'b0;
        tick();
        classify(8'hA5, eh, ec, en);
        m_hit = eh; m_cat = ec; m_err = err_of(en);
        check_all("wait_rst", 1'b1, 1'b0);
        in_ready_dn = 1'b1;
        do_reset();
        in_ready_dn = 1'b0;
        check_all("mid_rst", 1'b0, 1'b1);
        tick();
        check_all("post_rst", 1'b0, 1'b1);

        // Reset cleared all enables
        run_item(8'hA5, 0, 1'b0, 0, 8'h00, 8'h00, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
